// File: rtl/button_reader_pkg.sv
// Shared constants for the board I/O blocks: debounce state encoding and the
// default debounce period, which the LED logic also uses as its tick period.
package button_reader_pkg;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1023;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_cell.sv
// One button channel: 2-flop synchroniser, debounce counter/FSM, debounced
// level and one-cycle press/release pulses.
module debounce_cell
    import button_reader_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = 32
) (
    input  logic CLK,
    input  logic RST,
    input  logic pin_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic press_next_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync2_q;
    db_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values; blocking here would collapse the synchroniser.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            ST_STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = ST_COUNTING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_COUNTING: begin
                if (sync2_q == level_q) begin
                    // Bounce back to the old level: drop the partial count.
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_STABLE;
                    cnt_d     = '0;
                    level_d   = sync2_q;
                    press_d   = sync2_q;
                    release_d = ~sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_STABLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o      = level_q;
    assign press_o      = press_q;
    assign release_o    = release_q;
    assign press_next_o = press_d;

endmodule

// File: rtl/button_reader.sv
// WIDTH debounced button inputs with press/release pulses and a wrap-around
// count of all press events.
module button_reader
    import button_reader_pkg::*;
#(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_WIDTH       = 32,
    parameter int unsigned ACTIVE_HIGH     = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] BTN,
    output logic [WIDTH-1:0] BTN_LEVEL,
    output logic [WIDTH-1:0] BTN_PRESS,
    output logic [WIDTH-1:0] BTN_RELEASE,
    output logic [WIDTH-1:0] PRESS_COUNT
);

    // Active-low pins are inverted so everything downstream sees 1 = pressed.
    localparam logic [WIDTH-1:0] POL_MASK = (ACTIVE_HIGH != 0) ? '0 : '1;

    logic [WIDTH-1:0] pin_w;
    logic [WIDTH-1:0] press_next_w;
    logic [WIDTH-1:0] press_sum;
    logic [WIDTH-1:0] count_q, count_d;

    assign pin_w = BTN ^ POL_MASK;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        debounce_cell #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_cell (
            .CLK         (CLK),
            .RST         (RST),
            .pin_i       (pin_w[i]),
            .level_o     (BTN_LEVEL[i]),
            .press_o     (BTN_PRESS[i]),
            .release_o   (BTN_RELEASE[i]),
            .press_next_o(press_next_w[i])
        );
    end

    // Count from the next-state pulses so the total updates on the same edge
    // the pulses appear; WIDTH bits always hold a popcount of WIDTH bits.
    always_comb begin
        press_sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            press_sum = press_sum + WIDTH'(press_next_w[i]);
        end
        count_d = count_q + press_sum;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign PRESS_COUNT = count_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: WIDTH=8, DEBOUNCE_CYCLES=4, one active-high
// and one active-low instance sharing clock and reset.
module tb_button_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] btn_h = 8'h00;
    logic [7:0] btn_l = 8'hFF;
    logic [7:0] level_h, press_h, release_h, count_h;
    logic [7:0] level_l, press_l, release_l, count_l;

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    button_reader #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8), .ACTIVE_HIGH(1)
    ) dut_h (
        .CLK(clk), .RST(rst), .BTN(btn_h),
        .BTN_LEVEL(level_h), .BTN_PRESS(press_h),
        .BTN_RELEASE(release_h), .PRESS_COUNT(count_h)
    );

    button_reader #(
        .WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_WIDTH(8), .ACTIVE_HIGH(0)
    ) dut_l (
        .CLK(clk), .RST(rst), .BTN(btn_l),
        .BTN_LEVEL(level_l), .BTN_PRESS(press_l),
        .BTN_RELEASE(release_l), .PRESS_COUNT(count_l)
    );

    // Advance n rising edges; afterwards we sit 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst   = 1'b0;
        btn_h = 8'hFF;
        btn_l = 8'h00;
        step(3);
        tests_run++;
        if (level_h !== 8'h00) begin failed++; $display("FAIL reset_level: got %h want 00", level_h); end
        tests_run++;
        if (press_h !== 8'h00 || release_h !== 8'h00) begin
            failed++; $display("FAIL reset_pulses: got press %h release %h want 00/00", press_h, release_h);
        end
        tests_run++;
        if (count_h !== 8'h00) begin failed++; $display("FAIL reset_count: got %h want 00", count_h); end
        tests_run++;
        if (level_l !== 8'h00 || count_l !== 8'h00) begin
            failed++; $display("FAIL reset_low_pol: got level %h count %h want 00/00", level_l, count_l);
        end

        // All eight pins pressed out of reset: flip on edge 6, count += 8.
        rst = 1'b1;
        step(6);
        tests_run++;
        if (level_h !== 8'hFF || press_h !== 8'hFF) begin
            failed++; $display("FAIL reset_all_press: got level %h press %h want FF/FF", level_h, press_h);
        end
        tests_run++;
        if (count_h !== 8'h08) begin failed++; $display("FAIL reset_all_count: got %h want 08", count_h); end

        // Asynchronous assertion between edges clears everything without a clock.
        #3;
        rst = 1'b0;
        #1;
        tests_run++;
        if (level_h !== 8'h00 || press_h !== 8'h00 || count_h !== 8'h00) begin
            failed++; $display("FAIL reset_async: got level %h press %h count %h want 00/00/00", level_h, press_h, count_h);
        end
        tests_run++;
        if (level_l !== 8'h00 || count_l !== 8'h00) begin
            failed++; $display("FAIL reset_async_low: got level %h count %h want 00/00", level_l, count_l);
        end
        btn_h = 8'h00;
        btn_l = 8'hFF;
        step(2);
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_clean_press;
        btn_h = 8'h01;
        step(5);
        tests_run++;
        if (level_h !== 8'h00 || press_h !== 8'h00) begin
            failed++; $display("FAIL press_early: edge5 level %h press %h want 00/00", level_h, press_h);
        end
        step(1);
        tests_run++;
        if (level_h !== 8'h01 || press_h !== 8'h01 || release_h !== 8'h00) begin
            failed++; $display("FAIL press_edge6: level %h press %h release %h want 01/01/00", level_h, press_h, release_h);
        end
        tests_run++;
        if (count_h !== 8'h01) begin failed++; $display("FAIL press_count: got %h want 01", count_h); end
        step(1);
        tests_run++;
        if (press_h !== 8'h00 || level_h !== 8'h01) begin
            failed++; $display("FAIL press_one_cycle: edge7 press %h level %h want 00/01", press_h, level_h);
        end

        btn_h = 8'h00;
        step(5);
        tests_run++;
        if (release_h !== 8'h00 || level_h !== 8'h01) begin
            failed++; $display("FAIL release_early: edge5 release %h level %h want 00/01", release_h, level_h);
        end
        step(1);
        tests_run++;
        if (release_h !== 8'h01 || press_h !== 8'h00 || level_h !== 8'h00) begin
            failed++; $display("FAIL release_edge6: release %h press %h level %h want 01/00/00", release_h, press_h, level_h);
        end
        tests_run++;
        if (count_h !== 8'h01) begin failed++; $display("FAIL release_count: got %h want 01", count_h); end
        step(1);
        tests_run++;
        if (release_h !== 8'h00) begin failed++; $display("FAIL release_one_cycle: got %h want 00", release_h); end
    endtask

    task automatic test_bounce;
        logic [7:0] seen;
        seen = 8'h00;
        // 1,0,1,0 every two cycles, then hold 0.
        for (int k = 0; k < 4; k++) begin
            btn_h = (k % 2 == 0) ? 8'h08 : 8'h00;
            for (int j = 0; j < 2; j++) begin
                step(1);
                seen = seen | press_h | release_h;
            end
        end
        for (int j = 0; j < 10; j++) begin
            step(1);
            seen = seen | press_h | release_h;
        end
        tests_run++;
        if (seen !== 8'h00 || level_h[3] !== 1'b0) begin
            failed++; $display("FAIL bounce_toggle: pulses %h level3 %b want 00/0", seen, level_h[3]);
        end

        // Three-cycle glitch: rejected.
        btn_h = 8'h08;
        step(3);
        seen = press_h | release_h;
        btn_h = 8'h00;
        for (int j = 0; j < 10; j++) begin
            step(1);
            seen = seen | press_h | release_h;
        end
        tests_run++;
        if (seen !== 8'h00 || level_h !== 8'h00) begin
            failed++; $display("FAIL glitch3: pulses %h level %h want 00/00", seen, level_h);
        end

        // Four-cycle glitch: level flips on edge 6, flips back on edge 10.
        btn_h = 8'h08;
        step(4);
        btn_h = 8'h00;
        step(2);
        tests_run++;
        if (press_h !== 8'h08 || level_h !== 8'h08) begin
            failed++; $display("FAIL glitch4_press: press %h level %h want 08/08", press_h, level_h);
        end
        step(4);
        tests_run++;
        if (release_h !== 8'h08 || level_h !== 8'h00) begin
            failed++; $display("FAIL glitch4_release: release %h level %h want 08/00", release_h, level_h);
        end
        tests_run++;
        if (count_h !== 8'h02) begin failed++; $display("FAIL glitch4_count: got %h want 02", count_h); end
        step(2);
    endtask

    task automatic test_simultaneous;
        btn_h = 8'h0F;
        step(5);
        tests_run++;
        if (press_h !== 8'h00 || count_h !== 8'h02) begin
            failed++; $display("FAIL simul_early: press %h count %h want 00/02", press_h, count_h);
        end
        step(1);
        tests_run++;
        if (press_h !== 8'h0F || level_h !== 8'h0F) begin
            failed++; $display("FAIL simul_press: press %h level %h want 0F/0F", press_h, level_h);
        end
        tests_run++;
        if (count_h !== 8'h06) begin failed++; $display("FAIL simul_count: got %h want 06", count_h); end
        step(1);
        tests_run++;
        if (press_h !== 8'h00 || count_h !== 8'h06) begin
            failed++; $display("FAIL simul_one_cycle: press %h count %h want 00/06", press_h, count_h);
        end
        btn_h = 8'h00;
        step(8);
    endtask

    task automatic test_wrap;
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        for (int n = 1; n <= 257; n++) begin
            btn_h = 8'h80;
            step(6);
            btn_h = 8'h00;
            step(6);
            if (n == 255) begin
                tests_run++;
                if (count_h !== 8'hFF) begin failed++; $display("FAIL wrap_255: got %h want FF", count_h); end
            end
            if (n == 256) begin
                tests_run++;
                if (count_h !== 8'h00) begin failed++; $display("FAIL wrap_256: got %h want 00", count_h); end
            end
        end
        tests_run++;
        if (count_h !== 8'h01) begin failed++; $display("FAIL wrap_257: got %h want 01", count_h); end
    endtask

    task automatic test_polarity;
        // btn_l has idled at FF (released) since the last reset.
        tests_run++;
        if (level_l !== 8'h00 || count_l !== 8'h00 || press_l !== 8'h00) begin
            failed++; $display("FAIL pol_idle: level %h count %h press %h want 00/00/00", level_l, count_l, press_l);
        end
        btn_l = 8'hFB;
        step(5);
        tests_run++;
        if (press_l !== 8'h00) begin failed++; $display("FAIL pol_early: got %h want 00", press_l); end
        step(1);
        tests_run++;
        if (press_l !== 8'h04 || level_l !== 8'h04 || count_l !== 8'h01) begin
            failed++; $display("FAIL pol_press: press %h level %h count %h want 04/04/01", press_l, level_l, count_l);
        end
        btn_l = 8'hFF;
        step(8);
    endtask

    task automatic test_reset_mid_count;
        btn_h = 8'h02;
        step(3);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(5);
        tests_run++;
        if (press_h !== 8'h00 || level_h !== 8'h00) begin
            failed++; $display("FAIL midrst_early: edge5 press %h level %h want 00/00", press_h, level_h);
        end
        step(1);
        tests_run++;
        if (press_h !== 8'h02 || level_h !== 8'h02) begin
            failed++; $display("FAIL midrst_press: edge6 press %h level %h want 02/02", press_h, level_h);
        end
        tests_run++;
        if (count_h !== 8'h01) begin failed++; $display("FAIL midrst_count: got %h want 01", count_h); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_wrap();
        test_polarity();
        test_reset_mid_count();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side companion to the LED blinker: reads WIDTH push-button/switch pins instead of driving LED pins.
- Per pin: synchronises, debounces, and emits a stable level plus one-cycle press and release pulses.
- Keeps a wrap-around count of all press events.
- Sits between board input pins and user logic, in the same clock domain as the LED logic.

Parameters:
- WIDTH, 8, number of button inputs; also the width of PRESS_COUNT.
- DEBOUNCE_CYCLES, 1023, consecutive cycles a synchronised input must differ from the stable level before the level flips. Legal range is 2 or more.
- CNT_WIDTH, 32, width of each per-pin debounce counter. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- ACTIVE_HIGH, 1, pin polarity. 1 means pin high = pressed; 0 means pin low = pressed, and pins are inverted before the synchroniser.

Ports:
- CLK  input  1  sole clock, rising edge.
- RST  input  1  reset, asynchronous assert, active-low (0 = reset). Deassertion is synchronised externally.
- BTN  input  WIDTH  raw asynchronous button pins.
- BTN_LEVEL  output  WIDTH  debounced level, 1 = pressed. Registered.
- BTN_PRESS  output  WIDTH  one-cycle pulse per bit on a debounced 0->1 transition. Registered.
- BTN_RELEASE  output  WIDTH  one-cycle pulse per bit on a debounced 1->0 transition. Registered.
- PRESS_COUNT  output  WIDTH  total press events, modulo 2^WIDTH. Registered.

Behaviour:
- Reset (RST=0, asynchronous): all of the following are 0 regardless of CLK:
  - synchroniser flops (value after polarity inversion, i.e. "released")
  - debounce counters and stable levels
  - BTN_LEVEL, BTN_PRESS, BTN_RELEASE, PRESS_COUNT
- Reset mid-debounce discards partial counts. After release, a pin held pressed needs the full 2+DEBOUNCE_CYCLES cycles again.
- Polarity: p[i] = ACTIVE_HIGH ? BTN[i] : ~BTN[i]. p feeds a 2-flop synchroniser, giving s[i].
- Per-bit state machine, states STABLE and COUNTING:
  - STABLE, s==level: counter held at 0.
  - STABLE, s!=level: go to COUNTING, counter=1.
  - COUNTING, s==level (bounce): go to STABLE, counter=0, no output change.
  - COUNTING, s!=level, counter<DEBOUNCE_CYCLES-1: counter+1.
  - COUNTING, s!=level, counter==DEBOUNCE_CYCLES-1: level<=s, counter=0, go to STABLE.
  - On that same edge, BTN_PRESS[i]=1 if s=1, else BTN_RELEASE[i]=1.
- Latency: a clean pin step flips BTN_LEVEL on the (2+DEBOUNCE_CYCLES)-th rising edge after the first edge that samples the new pin value. Pulses assert on that same edge and last exactly one cycle.
- Any bounce shorter than DEBOUNCE_CYCLES synchronised cycles produces no level change and no pulse.
- BTN_PRESS and BTN_RELEASE are never both 1 on one bit in one cycle.
- PRESS_COUNT adds popcount(next BTN_PRESS) on the edge the pulses assert. Simultaneous presses on k bits add k in one cycle.
- PRESS_COUNT wraps from 2^WIDTH-1 to 0 silently; there is no saturation or overflow flag.
- Counter arithmetic is unsigned at CNT_WIDTH bits; it never exceeds DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_STABLE=1'b0, ST_COUNTING=1'b1
  - default DEBOUNCE_CYCLES constant (1023), shared with the LED tick period
- Sub-module debounce_cell is generated WIDTH times. Its contents:
  - synchroniser, counter and state machine
  - level register and press/release pulse registers
- Top level holds the generate loop, the polarity inversion, and the popcount accumulator for PRESS_COUNT.

Test Plan:
All scenarios use WIDTH=8, DEBOUNCE_CYCLES=4, ACTIVE_HIGH=1 unless stated.
- Reset: hold RST=0 with BTN=8'hFF, toggle CLK -> all outputs 0. Assert RST=0 between edges -> outputs clear with no clock.
- Clean press: release RST, BTN[0] 0->1 held -> BTN_LEVEL[0]=1 and BTN_PRESS[0]=1 on edge 6, pulse gone at edge 7, PRESS_COUNT=1. Then BTN[0] 1->0 -> BTN_RELEASE[0] pulse on edge 6 after the change, PRESS_COUNT stays 1.
- Bounce rejection: BTN[3] toggles 1,0,1,0 every 2 cycles then holds 0 -> no pulses, BTN_LEVEL[3]=0. Glitch of 3 synchronised cycles -> no change. Glitch of 4 cycles -> level flips.
- Simultaneous: BTN 8'h00->8'h0F in one cycle -> BTN_PRESS=8'h0F for one cycle, PRESS_COUNT increments by 4.
- Wrap and polarity: 257 single presses on bit 7 -> PRESS_COUNT=1. With ACTIVE_HIGH=0, BTN idle 8'hFF after reset -> no pulses; BTN[2]=0 held -> BTN_PRESS[2] pulse.
- Reset mid-count: BTN[1] high for 3 cycles, RST=0 for 1 cycle, then release -> BTN_PRESS[1] only 2+4 edges after RST deasserts.
